// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ==========================================================================
// fifo_arb_pkg : shared types and round-robin search for fifo_wr_arbiter
// Rev 1.0
// ==========================================================================
package fifo_arb_pkg;

  localparam int N_MAX   = 16;
  localparam int IDW_MAX = $clog2(N_MAX);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} arb_state_t;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_XFER = 1'b1;

  // Search starts at ptr+1 and wraps modulo n; the first requester wins.
  function automatic int rr_pick(input logic [N_MAX-1:0] req, input int ptr, input int n);
    int                 win;
    int                 idx;
    logic               found;
    logic [N_MAX-1:0]   sh;
    win   = 0;
    found = 1'b0;
    for (int i = 1; i <= N_MAX; i++) begin
      if (i <= n) begin
        idx = (ptr + i) % n;
        sh  = req >> idx;
        if (!found && sh[0]) begin
          win   = idx;
          found = 1'b1;
        end
      end
    end
    return win;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ==========================================================================
// rr_arbiter : combinational N-way round-robin picker
// Rev 1.0
// ==========================================================================
module rr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] gnt_idx,
  output logic           any_req
);

  assign gnt_idx = IDW'(rr_pick(N_MAX'(req), int'(ptr), N));
  assign any_req = |req;

endmodule
`default_nettype wire

// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ==========================================================================
// fifo_wr_arbiter : packet-aware round-robin share of one FIFO write port
// Optional macro FIFO_ARB_SPACE_GATE_EN: grant only when fifo_space >= PKT_MAX
// Rev 1.0
// ==========================================================================
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N       = 4,
  parameter int WIDTH   = 32,
  parameter int PKT_MAX = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [N*WIDTH-1:0]   s_tdata,
  input  logic [N-1:0]         s_tlast,
  input  logic [N-1:0]         s_tvalid,
  output logic [N-1:0]         s_tready,
  output logic [WIDTH-1:0]     m_tdata,
  output logic                 m_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  input  logic [15:0]          fifo_space,
  output logic [$clog2(N)-1:0] grant_id,
  output logic                 busy
);

  localparam int IDW = $clog2(N);
  localparam logic [IDW-1:0] C_PTR_RST = IDW'(N - 1);

  logic [0:0]     r_state;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_grant;
  logic [IDW-1:0] w_pick;
  logic           w_any_req;
  logic           w_gate_open;
  logic           w_last_beat;

  rr_arbiter #(
    .N   (N),
    .IDW (IDW)
  ) u_rr (
    .req     (s_tvalid),
    .ptr     (r_ptr),
    .gnt_idx (w_pick),
    .any_req (w_any_req)
  );

`ifdef FIFO_ARB_SPACE_GATE_EN
  assign w_gate_open = (32'(fifo_space) >= PKT_MAX);
`else
  logic w_unused_space;
  assign w_unused_space = ^fifo_space;
  assign w_gate_open    = 1'b1;
`endif

  // Zero-latency pass-through for the granted producer; everything idle otherwise.
  always_comb begin
    s_tready = '0;
    m_tvalid = 1'b0;
    m_tdata  = '0;
    m_tlast  = 1'b0;
    if (r_state == ST_XFER) begin
      m_tvalid          = s_tvalid[r_grant];
      m_tdata           = s_tdata[r_grant*WIDTH +: WIDTH];
      m_tlast           = s_tlast[r_grant];
      s_tready[r_grant] = m_tready;
    end
  end

  assign w_last_beat = (r_state == ST_XFER) && s_tvalid[r_grant] && m_tready && s_tlast[r_grant];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= C_PTR_RST;
      r_grant <= '0;
    end else if (clear) begin
      r_state <= ST_IDLE;
      r_ptr   <= C_PTR_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_req && w_gate_open) begin
            r_grant <= w_pick;
            r_state <= ST_XFER;
          end
        end
        ST_XFER: begin
          // Pointer only moves at packet end so waiting producers are bounded.
          if (w_last_beat) begin
            r_ptr   <= r_grant;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant_id = r_grant;
  assign busy     = (r_state == ST_XFER);

endmodule
`default_nettype wire
